// File: rtl/pl_muldiv_ctrl_pkg.sv
// pl_muldiv_ctrl_pkg - op and state codes shared by the mul/div sequencer.
// This file also carries the pl_mips MD_OP_* / MD_ST_* defines, so it must be
// compiled ahead of the other rtl/ files.
// Optional feature macro (used by pl_muldiv_ctrl): PL_MULDIV_EARLY_OUT_EN.
`ifndef PL_MIPS_MD_DEFINES
`define PL_MIPS_MD_DEFINES
`define MD_OP_MULT  2'b00
`define MD_OP_MULTU 2'b01
`define MD_OP_DIV   2'b10
`define MD_OP_DIVU  2'b11
`define MD_ST_IDLE  2'b00
`define MD_ST_CALC  2'b01
`define MD_ST_FIX   2'b10
`endif

package pl_muldiv_ctrl_pkg;

  localparam logic [1:0] OP_MULT  = `MD_OP_MULT;
  localparam logic [1:0] OP_MULTU = `MD_OP_MULTU;
  localparam logic [1:0] OP_DIV   = `MD_OP_DIV;
  localparam logic [1:0] OP_DIVU  = `MD_OP_DIVU;

  typedef enum logic [1:0] {
    ST_IDLE = `MD_ST_IDLE,
    ST_CALC = `MD_ST_CALC,
    ST_FIX  = `MD_ST_FIX
  } md_state_e;

  // Bit 1 of the op code selects divide, bit 0 selects unsigned.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/pl_muldiv_step.sv
// pl_muldiv_step - one combinational iteration of the mul/div datapath.
// Multiply: acc = {partial product, unconsumed multiplier bits}; add the
// multiplicand when the multiplier LSB is set, then shift right.
// Divide: acc = {partial remainder, unconsumed dividend bits}; shift left and
// subtract the divisor when it fits (restoring). The quotient bit is returned
// separately; acc_next leaves bit 0 clear for the caller to fill.
module pl_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_next,
  output logic              q_bit
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] trial;

  // Single shift-add or restoring-subtract step.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb infers a latch).
    acc_next = '0;
    q_bit    = 1'b0;
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? operand : '0)};
    trial    = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, operand};
    if (is_div) begin
      q_bit    = ~trial[XLEN+1];
      acc_next = q_bit ? {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                       : {acc[2*XLEN-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/pl_muldiv_ctrl.sv
// pl_muldiv_ctrl - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// IDLE -> CALC (XLEN steps) -> FIX (sign fix-up, HI/LO write) -> IDLE.
// Divide by zero finishes straight from IDLE with div_zero and no writeback.
// Optional macro PL_MULDIV_EARLY_OUT_EN: multiplies leave CALC as soon as the
// remaining multiplier bits are all zero.
module pl_muldiv_ctrl
  import pl_muldiv_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      md_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  input  logic            hilo_rd,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic            stall_req
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   operand_q;
  logic              div_q;
  logic              neg_q;    // negate product / quotient at FIX
  logic              neg_r;    // negate remainder at FIX

  logic              op_div, op_signed, div_by_zero, calc_last, early_exit;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [2*XLEN-1:0] step_acc, acc_step, acc_calc, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic              step_q;

  assign op_div      = op_is_div(md_op);
  assign op_signed   = op_is_signed(md_op);
  assign div_by_zero = op_div & (src_b == '0);
  assign abs_a       = (op_signed & src_a[XLEN-1]) ? -src_a : src_a;
  assign abs_b       = (op_signed & src_b[XLEN-1]) ? -src_b : src_b;
  assign calc_last   = (count_q == CNT_W'(XLEN - 1));

  pl_muldiv_step #(.XLEN(XLEN)) u_step (
    .acc      (acc_q),
    .operand  (operand_q),
    .is_div   (div_q),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // The step leaves bit 0 clear on divide; the quotient bit drops in there.
  assign acc_step = step_acc | {{(2*XLEN-1){1'b0}}, step_q};

`ifdef PL_MULDIV_EARLY_OUT_EN
  logic [CNT_W:0] bits_done;

  // After bits_done steps the unconsumed multiplier bits sit in
  // acc_step[XLEN-1-bits_done:0]; when they are zero the product is complete
  // and only needs shifting down by the steps that were skipped.
  assign bits_done  = {1'b0, count_q} + (CNT_W+1)'(1);
  assign early_exit = ~div_q & ((acc_step[XLEN-1:0] << bits_done) == '0);
  assign acc_calc   = early_exit ? (acc_step >> ((CNT_W+1)'(XLEN) - bits_done))
                                 : acc_step;
`else
  assign early_exit = 1'b0;
  assign acc_calc   = acc_step;
`endif

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = neg_r ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush returns to IDLE from anywhere and beats start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start && !flush && !div_by_zero) state_d = ST_CALC;
      ST_CALC: begin
        if (flush)                        state_d = ST_IDLE;
        else if (calc_last || early_exit) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    stall_req = busy & (hilo_rd | start);
  end

  // Datapath: operand capture, iteration, fix-up and HI/LO writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      count_q   <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start && !flush) begin
            if (div_by_zero) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              acc_q     <= {{XLEN{1'b0}}, (op_div ? abs_a : abs_b)};
              operand_q <= op_div ? abs_b : abs_a;
              div_q     <= op_div;
              neg_q     <= op_signed & (src_a[XLEN-1] ^ src_b[XLEN-1]);
              neg_r     <= op_signed & src_a[XLEN-1];
              count_q   <= '0;
            end
          end
        end
        ST_CALC: begin
          if (!flush) begin
            acc_q   <= acc_calc;
            count_q <= count_q + CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (!flush) begin
            hi   <= div_q ? rem_fix : prod_fix[2*XLEN-1:XLEN];
            lo   <= div_q ? quo_fix : prod_fix[XLEN-1:0];
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pl_muldiv_ctrl.sv
// tb_pl_muldiv_ctrl - directed, table-driven bench for pl_muldiv_ctrl.
// Cycle n is the clock period following rising edge n; start is presented in
// cycle 0. Inputs change 1 ns after a rising edge, outputs are read 1 ns later.
module tb_pl_muldiv_ctrl;
  import pl_muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        flush, hilo_rd;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero, stall_req;

  int n_pass  = 0;
  int n_total = 0;

  pl_muldiv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .md_op     (md_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .hilo_rd   (hilo_rd),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat_base;   // done cycle without early-out
    int          lat_early;  // done cycle with early-out
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle and follow it until done (bounded).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt,
                        output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
    lat = -1; busy_cnt = 0; rhi = 'x; rlo = 'x; rdz = 1'bx;
    md_op = op; src_a = a; src_b = b; start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      next_cycle();
      start = 1'b0;
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        lat = c; rhi = hi; rlo = lo; rdz = div_zero;
        break;
      end
    end
  endtask

  // Wait for a done pulse with a cycle budget.
  task automatic wait_done(output logic seen);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      next_cycle();
      start = 1'b0;
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, bcnt, exp_lat;
    logic [31:0] rhi, rlo;
    logic        rdz, seen, ok_a, ok_b, ok_c, no_done;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 4};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 34, 4};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 34};
    vecs[3]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        34, 34};
    vecs[4]  = '{OP_MULTU, 32'd10,        32'd3,         32'd0,         32'd30,        34, 4};
    vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 34};
    vecs[6]  = '{OP_MULT,  32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hEDCB_A988, 34, 3};
    vecs[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34, 34};
    vecs[8]  = '{OP_MULTU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34, 34};
    vecs[9]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 34, 34};
    vecs[10] = '{OP_DIVU,  32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022, 34, 34};

    rst = 1'b1; start = 1'b0; md_op = OP_MULT; src_a = '0; src_b = '0;
    flush = 1'b0; hilo_rd = 1'b0;

    // Reset state.
    #2;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_div_zero", div_zero, 0);
    start = 1'b1; hilo_rd = 1'b1;
    #1;
    check("reset_stall_req", stall_req, 0);
    start = 1'b0; hilo_rd = 1'b0;
    #4 rst = 1'b0;
    next_cycle();

    // Table of ops; each starts in the done cycle of the previous one.
    for (int i = 0; i < NVEC; i++) begin
`ifdef PL_MULDIV_EARLY_OUT_EN
      exp_lat = vecs[i].lat_early;
`else
      exp_lat = vecs[i].lat_base;
`endif
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, rhi, rlo, rdz);
      check($sformatf("vec%0d_done_cycle", i), lat, exp_lat);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, exp_lat - 1);
      check($sformatf("vec%0d_hi", i), rhi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), rlo, vecs[i].exp_lo);
      check($sformatf("vec%0d_div_zero", i), rdz, 0);
    end

    // Divide by zero with HI=0x11 / LO=0x22 left by the last vector.
    run_op(OP_DIVU, 32'd5, 32'd0, lat, bcnt, rhi, rlo, rdz);
    check("divu0_done_cycle", lat, 1);
    check("divu0_busy_cycles", bcnt, 0);
    check("divu0_div_zero", rdz, 1);
    check("divu0_hi", rhi, 32'h11);
    check("divu0_lo", rlo, 32'h22);
    next_cycle();
    check("divu0_done_pulse", done, 0);
    check("divu0_flag_pulse", div_zero, 0);
    run_op(OP_DIV, 32'hFFFF_FFFD, 32'd0, lat, bcnt, rhi, rlo, rdz);
    check("div0_done_cycle", lat, 1);
    check("div0_busy_cycles", bcnt, 0);
    check("div0_div_zero", rdz, 1);
    check("div0_lo", rlo, 32'h22);

    // Hazard sequence: ignored restart at cycle 5, MFHI/MFLO stall from
    // cycle 10, back-to-back start in the done cycle.
    md_op = OP_MULTU; src_a = 32'd3; src_b = 32'h8000_0001; start = 1'b1;
    ok_a = 1'b1; ok_b = 1'b1; ok_c = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      next_cycle();
      start = 1'b0;
      if (c == 5) begin
        md_op = OP_MULTU; src_a = 32'd7; src_b = 32'd7; start = 1'b1;
      end
      if (c == 34) begin
        md_op = OP_MULTU; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
      end
      hilo_rd = (c >= 10 && c <= 34);
      #1;
      if (c == 5) check("restart_stall_req", stall_req, 1);
      if (c >= 10 && c <= 33 && stall_req !== 1'b1) ok_a = 1'b0;
      if (c >= 1 && c <= 33) begin
        if (hi !== 32'h11 || lo !== 32'h22) ok_b = 1'b0;
        if (done !== 1'b0 || busy !== 1'b1) ok_c = 1'b0;
      end
      if (c == 34) begin
        check("hazard_done", done, 1);
        check("hazard_hi", hi, 32'h1);
        check("hazard_lo", lo, 32'h8000_0003);
        check("hazard_stall_at_done", stall_req, 0);
      end
      if (c == 35) check("b2b_busy", busy, 1);
    end
    hilo_rd = 1'b0;
    check("hilo_rd_stall_10_33", ok_a, 1);
    check("hilo_hold_until_done", ok_b, 1);
    check("busy_no_early_done", ok_c, 1);
    wait_done(seen);
    check("b2b_done_seen", seen, 1);
    check("b2b_hi", hi, 0);
    check("b2b_lo", lo, 32'd42);

    // Flush at cycle 20 of a divide.
    md_op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    no_done = 1'b1; ok_a = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      next_cycle();
      start = 1'b0;
      flush = (c == 20);
      #1;
      if (c <= 20 && busy !== 1'b1) ok_a = 1'b0;
      if (c == 21) check("flush_idle_at_21", busy, 0);
      if (done) no_done = 1'b0;
    end
    flush = 1'b0;
    check("flush_busy_1_20", ok_a, 1);
    check("flush_no_done", no_done, 1);
    check("flush_hi_kept", hi, 0);
    check("flush_lo_kept", lo, 32'd42);

    // flush and start together in IDLE: start dropped.
    md_op = OP_MULTU; src_a = 32'd5; src_b = 32'd5; start = 1'b1; flush = 1'b1;
    next_cycle();
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_start_idle", busy, 0);
    no_done = 1'b1;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      if (done) no_done = 1'b0;
    end
    check("flush_start_no_done", no_done, 1);
    check("flush_start_lo_kept", lo, 32'd42);

    // Asynchronous reset in the middle of a divide, then recovery.
    md_op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("midop_reset_busy", busy, 0);
    check("midop_reset_lo", lo, 0);
    check("midop_reset_done", done, 0);
    #1 rst = 1'b0;
    next_cycle();
    run_op(OP_DIVU, 32'd1000, 32'd3, lat, bcnt, rhi, rlo, rdz);
    check("post_reset_done_cycle", lat, 34);
    check("post_reset_lo", rlo, 32'd333);
    check("post_reset_hi", rhi, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pl_muldiv_ctrl.md
Name: pl_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer for the pipelined MIPS core. Executes MULT, MULTU, DIV and DIVU over multiple cycles, owns the HI/LO registers, and raises a stall request to the hazard unit.
- Sits beside the main ALU in EX. The EX decode path issues a one-cycle start; MFHI/MFLO read hi/lo through this block.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, $clog2(XLEN), iteration counter width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  issue a mul/div op; sampled only in IDLE.
- md_op  input  2  op select, encoded with the `MD_OP_*` codes.
- src_a  input  XLEN  rs value: multiplicand or dividend.
- src_b  input  XLEN  rt value: multiplier or divisor.
- flush  input  1  abort the op in flight; no HI/LO writeback.
- hilo_rd  input  1  EX holds MFHI/MFLO this cycle.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.
- busy  output  1  operation in flight (state != IDLE).
- done  output  1  one-cycle pulse; new hi/lo visible this cycle.
- div_zero  output  1  one-cycle pulse with done when DIV/DIVU had src_b == 0.
- stall_req  output  1  equals busy & (hilo_rd | start).

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
- States are IDLE, CALC and FIX.
- IDLE: start=1 latches operands into working registers.
  - Signed ops store |a| and |b| and record sign_q=a[31]^b[31] and sign_r=a[31].
  - Then go to CALC with count=0.
- CALC, multiply: shift-add, one multiplier bit per cycle, 2*XLEN accumulator.
- CALC, divide: restoring divide, one quotient bit per cycle.
- CALC exit: at the edge where count==XLEN-1, go to FIX. CALC therefore lasts XLEN cycles.
- FIX, signed multiply: negate the 64-bit product if sign_q.
- FIX, signed divide: negate the quotient if sign_q and the remainder if sign_r.
- FIX write: at its edge, write HI=product[63:32]/remainder and LO=product[31:0]/quotient. Go to IDLE and set done=1 for one cycle.
- Latency: start at cycle 0. busy is high in cycles 1..XLEN+1. done and the new hi/lo appear in cycle XLEN+2 (34 for XLEN=32).
- A new start is accepted in the done cycle.
- start while busy: ignored, with stall_req=1. The pipeline holds the instruction and re-presents it.
- hilo_rd while busy: stall_req=1. hi/lo keep their old value until done.
- Divide by zero: detected in IDLE at start.
  - No CALC. Next cycle: done=1, div_zero=1, busy never asserts.
  - HI/LO unchanged.
- INT_MIN / -1 (DIV): quotient wraps to 0x80000000, remainder 0. No flag.
- flush: any state goes to IDLE on the next edge.
  - HI/LO unchanged, no done pulse.
  - flush and start together in IDLE: flush wins, start is dropped.
- Reset mid-op: immediate return to the reset values.
- Undefined md_op: impossible by construction; all four codes are valid.

Optional Feature:
- Macro: `PL_MULDIV_EARLY_OUT_EN`.
- Defined: in CALC for MULT/MULTU, when the remaining unshifted multiplier bits are all zero, shift the accumulator into final position and go to FIX on that edge.
  - For src_b=3, done arrives in cycle 4.
  - Divide latency is unchanged.
- Undefined: fixed XLEN-cycle CALC for all ops.

Decomposition:
- pl_mips_defines.svh gets:
  - `MD_OP_MULT`=2'b00, `MD_OP_MULTU`=2'b01, `MD_OP_DIV`=2'b10, `MD_OP_DIVU`=2'b11;
  - the state encoding `MD_ST_IDLE`/`MD_ST_CALC`/`MD_ST_FIX`.
- One sub-module, pl_muldiv_step: combinational single iteration. Inputs are the accumulator, operand and mul/div select; outputs are the next accumulator and the next quotient bit.
- The FSM, counter, sign fix-up and HI/LO stay in pl_muldiv_ctrl.

Test Plan:
- MULT a=0xFFFFFFFF b=0x00000002 -> cycle 34: done=1, HI=0xFFFFFFFF, LO=0xFFFFFFFE; busy high in cycles 1..33.
- MULTU a=0xFFFFFFFF b=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also DIVU a=100 b=7 -> LO=14, HI=2.
- DIVU a=5 b=0 with HI=0x11, LO=0x22 preloaded -> cycle 1: done=1, div_zero=1, HI=0x11, LO=0x22, busy never high.
- MULT started, then hilo_rd=1 at cycle 10 -> stall_req=1 through cycle 33. Second start at cycle 5 is ignored. flush at cycle 20 on a new op -> IDLE at cycle 21, HI/LO unchanged, no done.
- With `PL_MULDIV_EARLY_OUT_EN`: MULTU a=10 b=3 -> done in cycle 4, HI=0, LO=30. Without the macro: done in cycle 34, same result.
